// File: rtl/usb_in_txn_ctrl.sv
// Host-side USB IN-transaction sequencer: sends the IN token, judges the device reply,
// ACKs good data, tracks DATA0/DATA1 and retries on NAK, corruption or timeout.
module usb_in_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        toggle_clr,
  output logic        tok_req,
  input  logic        tok_done,
  input  logic        rx_avail,
  input  logic        rx_valid,
  input  logic [98:0] rx_pkt,
  output logic        ack_req,
  input  logic        ack_done,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  output logic        txn_done,
  output logic [1:0]  txn_status,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST_ATTEMPT = AW'(MAX_RETRY);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RETRIES = 2'b01;
  localparam logic [1:0] ST_STALL   = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SEND_TOK, WAIT_RX, SEND_ACK, RETRY, DONE
  } state_t;

  state_t          state;
  logic            toggle;
  logic            discard;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   attempt;
  logic [63:0]     hold;

  logic            is_data;
  logic [3:0]      pid;
  logic [3:0]      exp_pid;
  logic [3:0]      dup_pid;
  logic [63:0]     payload;
  logic            unused_pkt_bits;

  assign is_data = (rx_pkt[98:91] == 8'h01);
  assign pid     = is_data ? rx_pkt[90:87] : rx_pkt[10:7];
  assign payload = rx_pkt[82:19];
  assign exp_pid = toggle ? PID_DATA1 : PID_DATA0;
  assign dup_pid = toggle ? PID_DATA0 : PID_DATA1;

  // Packet fields this sequencer never looks at (address/CRC/sync residue).
  assign unused_pkt_bits = ^{rx_pkt[86:83], rx_pkt[18:11], rx_pkt[6:0]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; the payload holding register is reset too because it
  // is small and feeds data_out, keeping post-reset behaviour fully defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      toggle         <= 1'b0;
      discard        <= 1'b0;
      timer          <= '0;
      attempt        <= '0;
      hold           <= '0;
      tok_req        <= 1'b0;
      ack_req        <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      txn_done       <= 1'b0;
      txn_status     <= ST_OK;
      busy           <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      txn_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (toggle_clr) toggle <= 1'b0;
          if (start) begin
            state   <= SEND_TOK;
            attempt <= AW'(1);
            discard <= 1'b0;
            tok_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SEND_TOK: begin
          if (tok_done) begin
            tok_req <= 1'b0;
            timer   <= '0;
            state   <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          // A packet arriving on the last timer cycle takes priority over the timeout.
          if (rx_avail) begin
            if (!rx_valid) begin
              state <= RETRY;
            end else if (is_data && pid == exp_pid) begin
              hold    <= payload;
              discard <= 1'b0;
              ack_req <= 1'b1;
              state   <= SEND_ACK;
            end else if (is_data && pid == dup_pid) begin
              discard <= 1'b1;
              ack_req <= 1'b1;
              state   <= SEND_ACK;
            end else if (pid == PID_STALL) begin
              txn_done   <= 1'b1;
              txn_status <= ST_STALL;
              state      <= DONE;
            end else begin
              state <= RETRY;
            end
          end else if (timer == TIMER_LAST) begin
            state <= RETRY;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SEND_ACK: begin
          if (ack_done) begin
            ack_req <= 1'b0;
            if (discard) begin
              discard <= 1'b0;
              state   <= RETRY;
            end else begin
              toggle         <= ~toggle;
              data_out       <= hold;
              data_out_valid <= 1'b1;
              txn_done       <= 1'b1;
              txn_status     <= ST_OK;
              state          <= DONE;
            end
          end
        end
        RETRY: begin
          if (attempt == LAST_ATTEMPT) begin
            txn_done   <= 1'b1;
            txn_status <= ST_RETRIES;
            state      <= DONE;
          end else begin
            attempt <= attempt + 1'b1;
            tok_req <= 1'b1;
            state   <= SEND_TOK;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_in_txn_ctrl.sv
// Randomized bench for usb_in_txn_ctrl: a per-transaction reference model feeds a
// scoreboard queue that a monitor drains on every txn_done.
module tb_usb_in_txn_ctrl;

  localparam int TIMEOUT   = 255;
  localparam int MAX_RETRY = 8;

  typedef enum {R_SILENT, R_CORRUPT, R_NAK, R_STALL, R_OTHER, R_D0, R_D1} kind_t;
  typedef struct {
    kind_t       kind;
    bit          late;
    logic [63:0] payload;
  } resp_t;
  typedef struct {
    logic [1:0]  status;
    bit          deliver;
    logic [63:0] data;
    int          n_tok;
    int          n_ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, toggle_clr = 1'b0;
  logic        tok_done = 1'b0, rx_avail = 1'b0, rx_valid = 1'b0, ack_done = 1'b0;
  logic [98:0] rx_pkt = '0;
  logic        tok_req, ack_req, data_out_valid, txn_done, busy;
  logic [63:0] data_out;
  logic [1:0]  txn_status;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  exp_q[$];
  resp_t plan[MAX_RETRY];
  bit    m_toggle = 1'b0;

  int          tok_cnt = 0, ack_cnt = 0;
  logic        prev_tok = 1'b0, prev_ack = 1'b0;
  logic [63:0] last_data = '0;

  usb_in_txn_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .toggle_clr(toggle_clr),
    .tok_req(tok_req), .tok_done(tok_done), .rx_avail(rx_avail), .rx_valid(rx_valid),
    .rx_pkt(rx_pkt), .ack_req(ack_req), .ack_done(ack_done), .data_out(data_out),
    .data_out_valid(data_out_valid), .txn_done(txn_done), .txn_status(txn_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the planned replies attempt by attempt.
  task automatic model_txn(input bit clr, output exp_t e);
    bit fin = 1'b0;
    if (clr) m_toggle = 1'b0;
    e = '{status: 2'b01, deliver: 1'b0, data: 64'h0, n_tok: 0, n_ack: 0};
    for (int a = 0; a < MAX_RETRY && !fin; a++) begin
      e.n_tok++;
      case (plan[a].kind)
        R_STALL: begin e.status = 2'b10; fin = 1'b1; end
        R_D0, R_D1: begin
          e.n_ack++;
          if ((plan[a].kind == R_D1) == m_toggle) begin
            e.status  = 2'b00;
            e.deliver = 1'b1;
            e.data    = plan[a].payload;
            m_toggle  = ~m_toggle;
            fin       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [98:0] mk_pkt(input resp_t r);
    logic [127:0] raw;
    logic [98:0]  p;
    raw = {$urandom, $urandom, $urandom, $urandom};
    p   = raw[98:0];
    case (r.kind)
      R_D0, R_D1, R_CORRUPT: begin
        p[98:91] = 8'h01;
        p[90:87] = (r.kind == R_D1) ? 4'b1011 : 4'b0011;
        p[82:19] = r.payload;
      end
      default: begin
        if (p[98:91] == 8'h01) p[98:91] = 8'h00;
        p[10:7] = (r.kind == R_NAK) ? 4'b1010 : (r.kind == R_STALL) ? 4'b1110 : 4'b0010;
      end
    endcase
    return p;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < MAX_RETRY; i++) plan[i] = '{R_SILENT, 1'b0, 64'h0};
  endtask

  task automatic wait_tok_or_done(output bit ok);
    int cnt = 0;
    while (!(tok_req || txn_done) && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    ok = (tok_req || txn_done);
    if (!ok) check("wait_tok_or_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_tok();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    tok_done = 1'b1;
    @(negedge clk);
    tok_done = 1'b0;
  endtask

  task automatic send_rx(input resp_t r);
    rx_pkt   = mk_pkt(r);
    rx_valid = (r.kind != R_CORRUPT);
    rx_avail = 1'b1;
    @(negedge clk);
    rx_avail = 1'b0;
    rx_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic do_txn(input bit clr, input bit start_busy);
    exp_t  e;
    resp_t r;
    bit    ok;
    bit    fin = 1'b0;
    int    idx = 0;
    int    d;
    int    cnt;
    model_txn(clr, e);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; toggle_clr = clr;
    @(negedge clk);
    start = 1'b0; toggle_clr = 1'b0;
    while (!fin) begin
      wait_tok_or_done(ok);
      if (!ok || txn_done) begin
        fin = 1'b1;
      end else begin
        pulse_tok();
        r = (idx < MAX_RETRY) ? plan[idx] : '{R_SILENT, 1'b0, 64'h0};
        idx++;
        if (r.kind == R_SILENT) begin
          cnt = 1;
          while (!(tok_req || txn_done) && cnt < 400) begin
            @(negedge clk);
            if (!(tok_req || txn_done)) cnt++;
          end
          check("silent_wait_cycles", 64'(cnt), 64'd256);
        end else begin
          d = r.late ? TIMEOUT - 1 : int'($urandom_range(0, 8));
          if (start_busy && d == 0) d = 1;
          for (int i = 0; i < d; i++) begin
            start = start_busy && (i == 0);
            @(negedge clk);
          end
          start = 1'b0;
          send_rx(r);
          if (ack_req) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack_done = 1'b1;
            @(negedge clk);
            ack_done = 1'b0;
          end
        end
      end
    end
  endtask

  // Monitor: counts handshake requests and scores each completed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      tok_cnt = 0; ack_cnt = 0; prev_tok = 1'b0; prev_ack = 1'b0; last_data = '0;
    end else begin
      if (tok_req && !prev_tok) tok_cnt++;
      if (ack_req && !prev_ack) ack_cnt++;
      prev_tok = tok_req;
      prev_ack = ack_req;
      if (txn_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("txn_status", 64'(txn_status), 64'(e.status));
          check("tok_req_count", 64'(tok_cnt), 64'(e.n_tok));
          check("ack_req_count", 64'(ack_cnt), 64'(e.n_ack));
          check("data_out_valid_with_done", 64'(data_out_valid), 64'(e.deliver));
          check("busy_in_done", 64'(busy), 64'd1);
          if (e.deliver) last_data = e.data;
          check("data_out", data_out, last_data);
        end
        tok_cnt = 0;
        ack_cnt = 0;
      end else begin
        if (data_out_valid) check("stray_data_out_valid", 64'd1, 64'd0);
        if (data_out !== last_data) check("data_out_hold", data_out, last_data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tok_req"}, 64'(tok_req), 64'd0);
    check({tag, "_ack_req"}, 64'(ack_req), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_txn_done"}, 64'(txn_done), 64'd0);
    check({tag, "_data_out_valid"}, 64'(data_out_valid), 64'd0);
    check({tag, "_txn_status"}, 64'(txn_status), 64'd0);
    check({tag, "_data_out"}, data_out, 64'd0);
  endtask

  task automatic reset_in_send_ack();
    bit    ok;
    resp_t r;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tok_or_done(ok);
    pulse_tok();
    r = '{m_toggle ? R_D1 : R_D0, 1'b0, 64'h5555_AAAA_1234_0FED};
    send_rx(r);
    check("ack_req_before_reset", 64'(ack_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    m_toggle = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // Clean transfer with DATA0.
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'hDEADBEEF_01234567};
    do_txn(1'b0, 1'b0);
    // NAK twice then DATA1.
    clear_plan();
    plan[0] = '{R_NAK, 1'b0, 64'h0};
    plan[1] = '{R_NAK, 1'b0, 64'h0};
    plan[2] = '{R_D1, 1'b0, 64'h0BAD_F00D_CAFE_0001};
    do_txn(1'b0, 1'b0);
    // Silent device: every attempt times out.
    clear_plan();
    do_txn(1'b0, 1'b0);
    // Corrupted reply, then good DATA0.
    clear_plan();
    plan[0] = '{R_CORRUPT, 1'b0, 64'h1111_2222_3333_4444};
    plan[1] = '{R_D0, 1'b0, 64'h9999_8888_7777_6666};
    do_txn(1'b0, 1'b0);
    // STALL.
    clear_plan();
    plan[0] = '{R_STALL, 1'b0, 64'h0};
    do_txn(1'b0, 1'b0);
    // Duplicate DATA0 while DATA1 expected, then DATA1.
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'hAAAA_0000_0000_0001};
    plan[1] = '{R_D1, 1'b0, 64'hBBBB_0000_0000_0002};
    do_txn(1'b0, 1'b0);
    // Reply on the very last timer cycle.
    clear_plan();
    plan[0] = '{R_D0, 1'b1, 64'hCCCC_1234_5678_9ABC};
    do_txn(1'b0, 1'b0);
    // start while busy is ignored.
    clear_plan();
    plan[0] = '{R_NAK, 1'b0, 64'h0};
    plan[1] = '{R_D1, 1'b0, 64'hDDDD_0102_0304_0506};
    do_txn(1'b0, 1'b1);
    // Get to DATA1, then toggle_clr with start expects DATA0.
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0};
    do_txn(1'b0, 1'b0);
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'h1357_9BDF_2468_ACE0};
    do_txn(1'b1, 1'b0);
    // Reset in SEND_ACK with DATA1 expected; afterwards DATA0 must be expected.
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'h7777_7777_0000_0001};
    do_txn(1'b0, 1'b0);
    reset_in_send_ack();
    clear_plan();
    plan[0] = '{R_D0, 1'b0, 64'hFACE_B00C_0000_0002};
    do_txn(1'b0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < MAX_RETRY; i++) begin
        int    u;
        kind_t k;
        u = int'($urandom_range(0, 15));
        k = (u == 0) ? R_SILENT : (u <= 2) ? R_CORRUPT : (u <= 5) ? R_NAK :
            (u == 6) ? R_STALL : (u == 7) ? R_OTHER : (u <= 11) ? R_D0 : R_D1;
        plan[i] = '{k, ($urandom_range(0, 19) == 0), {$urandom, $urandom}};
      end
      do_txn(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
